// File: rtl/ttl_csum_update.sv
// rtl/ttl_csum_update.sv - IPv4 TTL decrement with incremental header checksum patch, one registered stream stage
// Optional per-port modified-packet counters when TTL_PORT_CNT_EN is defined.
module ttl_csum_update #(
    parameter int C_S_AXI_DATA_WIDTH   = 32,
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int DST_PORT_POS         = 24
) (
    input  logic                                 AXI_ACLK,
    input  logic                                 AXI_RESET,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       S_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     S_AXIS_TSTRB,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      S_AXIS_TUSER,
    input  logic                                 S_AXIS_TVALID,
    input  logic                                 S_AXIS_TLAST,
    output logic                                 S_AXIS_TREADY,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]       M_AXIS_TDATA,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     M_AXIS_TSTRB,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]      M_AXIS_TUSER,
    output logic                                 M_AXIS_TVALID,
    output logic                                 M_AXIS_TLAST,
    input  logic                                 M_AXIS_TREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]        reset,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        ttl_dec_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        pass_count
`ifdef TTL_PORT_CNT_EN
    ,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        port0_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        port1_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        port2_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        port3_count
`endif
);

    typedef enum logic {SOP, IN_PKT} state_t;

    state_t state, next_state;

    logic        accept;
    logic        stat_clr;
    logic        modify;
    logic [7:0]  dst;
    logic [7:0]  ttl;
    logic [7:0]  proto;
    logic [15:0] hc;
    logic [16:0] sum1;
    logic [15:0] part;
    logic [16:0] sum2;
    logic [15:0] csum_new;
    logic [C_S_AXIS_DATA_WIDTH-1:0] out_data;

    assign S_AXIS_TREADY = !M_AXIS_TVALID || M_AXIS_TREADY;
    assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;
    assign stat_clr      = (reset == C_S_AXI_DATA_WIDTH'(1));

    assign dst   = S_AXIS_TUSER[DST_PORT_POS +: 8];
    assign ttl   = S_AXIS_TDATA[79:72];
    assign proto = S_AXIS_TDATA[71:64];
    assign hc    = S_AXIS_TDATA[63:48];

    // Even destination bits are MAC ports, odd bits are CPU ports.
    assign modify = (state == SOP)
                 && (S_AXIS_TDATA[159:144] == 16'h0800)
                 && (S_AXIS_TDATA[143:140] == 4'd4)
                 && (ttl >= 8'd2)
                 && ((dst & 8'h55) != 8'h00)
                 && ((dst & 8'hAA) == 8'h00);

    // HC' = ~(~HC +' ~m +' m'); one end-around fold per 16-bit add cannot carry again.
    assign sum1     = {1'b0, ~hc} + {1'b0, ~{ttl, proto}};
    assign part     = sum1[15:0] + {15'd0, sum1[16]};
    assign sum2     = {1'b0, part} + {1'b0, ttl - 8'd1, proto};
    assign csum_new = ~(sum2[15:0] + {15'd0, sum2[16]});

    always_comb begin
        out_data = S_AXIS_TDATA;
        if (modify) begin
            out_data[79:72] = ttl - 8'd1;
            out_data[63:48] = csum_new;
        end
    end

    always_comb begin
        next_state = state;
        if (accept) begin
            next_state = S_AXIS_TLAST ? SOP : IN_PKT;
        end
    end

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) begin
            state <= SOP;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) begin
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TDATA  <= '0;
            M_AXIS_TSTRB  <= '0;
            M_AXIS_TUSER  <= '0;
            M_AXIS_TLAST  <= 1'b0;
        end else if (S_AXIS_TREADY) begin
            M_AXIS_TVALID <= S_AXIS_TVALID;
            if (S_AXIS_TVALID) begin
                M_AXIS_TDATA <= out_data;
                M_AXIS_TSTRB <= S_AXIS_TSTRB;
                M_AXIS_TUSER <= S_AXIS_TUSER;
                M_AXIS_TLAST <= S_AXIS_TLAST;
            end
        end
    end

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET || stat_clr) begin
            ttl_dec_count <= '0;
            pass_count    <= '0;
        end else if (accept && (state == SOP)) begin
            if (modify) begin
                ttl_dec_count <= ttl_dec_count + 1'b1;
            end else begin
                pass_count <= pass_count + 1'b1;
            end
        end
    end

`ifdef TTL_PORT_CNT_EN
    logic [C_S_AXI_DATA_WIDTH-1:0] port_cnt [4];

    // Multicast to several MAC ports bumps every selected port.
    always_ff @(posedge AXI_ACLK) begin
        for (int i = 0; i < 4; i++) begin
            if (AXI_RESET || stat_clr) begin
                port_cnt[i] <= '0;
            end else if (accept && modify && dst[2*i]) begin
                port_cnt[i] <= port_cnt[i] + 1'b1;
            end
        end
    end

    assign port0_count = port_cnt[0];
    assign port1_count = port_cnt[1];
    assign port2_count = port_cnt[2];
    assign port3_count = port_cnt[3];
`endif

endmodule

// File: tb/tb_ttl_csum_update.sv
// tb/tb_ttl_csum_update.sv - self-checking bench for ttl_csum_update
module tb_ttl_csum_update;

    logic         clk = 1'b0;
    logic         AXI_RESET;
    logic [255:0] S_AXIS_TDATA;
    logic [31:0]  S_AXIS_TSTRB;
    logic [127:0] S_AXIS_TUSER;
    logic         S_AXIS_TVALID;
    logic         S_AXIS_TLAST;
    logic         S_AXIS_TREADY;
    logic [255:0] M_AXIS_TDATA;
    logic [31:0]  M_AXIS_TSTRB;
    logic [127:0] M_AXIS_TUSER;
    logic         M_AXIS_TVALID;
    logic         M_AXIS_TLAST;
    logic         M_AXIS_TREADY;
    logic [31:0]  stat_reset;
    logic [31:0]  ttl_dec_count;
    logic [31:0]  pass_count;
`ifdef TTL_PORT_CNT_EN
    logic [31:0]  port_count [4];
`endif

    always #5 clk = ~clk;

    ttl_csum_update dut (
        .AXI_ACLK      (clk),
        .AXI_RESET     (AXI_RESET),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TSTRB  (S_AXIS_TSTRB),
        .S_AXIS_TUSER  (S_AXIS_TUSER),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TSTRB  (M_AXIS_TSTRB),
        .M_AXIS_TUSER  (M_AXIS_TUSER),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .reset         (stat_reset),
        .ttl_dec_count (ttl_dec_count),
        .pass_count    (pass_count)
`ifdef TTL_PORT_CNT_EN
        ,
        .port0_count   (port_count[0]),
        .port1_count   (port_count[1]),
        .port2_count   (port_count[2]),
        .port3_count   (port_count[3])
`endif
    );

    typedef struct {
        logic [255:0] d;
        logic [31:0]  s;
        logic [127:0] u;
        logic         l;
    } beat_t;

    typedef struct {
        logic [15:0] et;
        logic [3:0]  ver;
        logic [7:0]  ttl;
        logic [7:0]  pr;
        logic [15:0] cs;
        logic [7:0]  dst;
        bit          mod;
        logic [7:0]  ettl;
        logic [15:0] ecs;
    } vec_t;

    int    errors = 0;
    int    checks = 0;
    int    n_out  = 0;
    int    tready_mode = 0;
    beat_t exp_q[$];
    int    m_dec = 0;
    int    m_pass = 0;
    int    m_port[4] = '{0, 0, 0, 0};
    bit    m_sop = 1'b1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: fields by byte offset, ones-complement sum of all three terms folded at the end.
    function automatic beat_t model(input beat_t b, input bit sop, output bit mod);
        beat_t       e;
        logic [7:0]  dst;
        bit          even;
        bit          odd;
        logic [15:0] nhc;
        logic [15:0] nm;
        logic [15:0] mp;
        int unsigned s;
        e    = b;
        dst  = b.u[31:24];
        even = 1'b0;
        odd  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (dst[i]) begin
                if (i % 2 == 0) even = 1'b1;
                else            odd  = 1'b1;
            end
        end
        mod = sop && b.d[159:144] == 16'h0800 && b.d[143:140] == 4'd4
              && b.d[79:72] >= 8'd2 && even && !odd;
        if (mod) begin
            nhc = ~b.d[63:48];
            nm  = ~b.d[79:64];
            mp  = {b.d[79:72] - 8'd1, b.d[71:64]};
            s   = nhc + nm + mp;
            while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
            e.d[79:72] = b.d[79:72] - 8'd1;
            e.d[63:48] = ~s[15:0];
        end
        return e;
    endfunction

    function automatic beat_t mk(input logic [15:0] et, input logic [3:0] ver, input logic [7:0] ttl,
                                 input logic [7:0] pr, input logic [15:0] cs, input logic [7:0] dst,
                                 input logic last);
        beat_t b;
        for (int i = 0; i < 8; i++) b.d[i*32 +: 32] = $urandom;
        for (int i = 0; i < 4; i++) b.u[i*32 +: 32] = $urandom;
        b.s          = $urandom;
        b.d[159:144] = et;
        b.d[143:140] = ver;
        b.d[79:72]   = ttl;
        b.d[71:64]   = pr;
        b.d[63:48]   = cs;
        b.u[31:24]   = dst;
        b.l          = last;
        return b;
    endfunction

    task automatic send(input beat_t b);
        bit    ok;
        bit    mod;
        beat_t e;
        ok            = 1'b0;
        S_AXIS_TDATA  = b.d;
        S_AXIS_TSTRB  = b.s;
        S_AXIS_TUSER  = b.u;
        S_AXIS_TLAST  = b.l;
        S_AXIS_TVALID = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (S_AXIS_TREADY) begin
                e = model(b, m_sop, mod);
                exp_q.push_back(e);
                if (m_sop) begin
                    if (mod) begin
                        m_dec++;
                        for (int p = 0; p < 4; p++) if (b.u[24 + 2*p]) m_port[p]++;
                    end else begin
                        m_pass++;
                    end
                end
                m_sop = b.l;
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        S_AXIS_TVALID = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_queue_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_ttl_dec_count"}, ttl_dec_count, m_dec);
        chk({tag, "_pass_count"}, pass_count, m_pass);
`ifdef TTL_PORT_CNT_EN
        for (int p = 0; p < 4; p++) chk({tag, "_port_count"}, port_count[p], m_port[p]);
`endif
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (tready_mode)
                0: M_AXIS_TREADY = 1'b1;
                1: M_AXIS_TREADY = ~M_AXIS_TREADY;
                2: M_AXIS_TREADY = ($urandom_range(0, 2) != 0);
                default: M_AXIS_TREADY = 1'b0;
            endcase
        end
    end

    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got beat %h expected none", M_AXIS_TDATA);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_tdata", M_AXIS_TDATA, e.d);
                    chk("out_tstrb", M_AXIS_TSTRB, e.s);
                    chk("out_tuser", M_AXIS_TUSER, e.u);
                    chk("out_tlast", M_AXIS_TLAST, e.l);
                    n_out++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tab[10];
        beat_t       b;
        int          tab_dec;
        int          n0;
        logic [7:0]  dsts[10];
        logic [15:0] et;
        logic [3:0]  ver;
        int          len;

        tab[0] = '{16'h0800, 4'd4, 8'h40, 8'h06, 16'hB1E6, 8'h01, 1'b1, 8'h3F, 16'hB2E6};
        tab[1] = '{16'h0800, 4'd4, 8'h05, 8'h11, 16'hFFFF, 8'h01, 1'b1, 8'h04, 16'h0100};
        tab[2] = '{16'h0800, 4'd4, 8'h01, 8'h06, 16'h1234, 8'h01, 1'b0, 8'h01, 16'h1234};
        tab[3] = '{16'h0806, 4'd4, 8'h40, 8'h06, 16'hB1E6, 8'h01, 1'b0, 8'h40, 16'hB1E6};
        tab[4] = '{16'h0800, 4'd4, 8'h40, 8'h06, 16'hB1E6, 8'h02, 1'b0, 8'h40, 16'hB1E6};
        tab[5] = '{16'h0800, 4'd4, 8'h40, 8'h06, 16'hB1E6, 8'h00, 1'b0, 8'h40, 16'hB1E6};
        tab[6] = '{16'h0800, 4'd4, 8'h02, 8'h06, 16'hB1E6, 8'h04, 1'b1, 8'h01, 16'hB2E6};
        tab[7] = '{16'h0800, 4'd6, 8'h40, 8'h06, 16'hB1E6, 8'h01, 1'b0, 8'h40, 16'hB1E6};
        tab[8] = '{16'h0800, 4'd4, 8'h40, 8'h06, 16'hB1E6, 8'h03, 1'b0, 8'h40, 16'hB1E6};
        tab[9] = '{16'h0800, 4'd4, 8'h40, 8'h06, 16'hB1E6, 8'h05, 1'b1, 8'h3F, 16'hB2E6};
        dsts   = '{8'h01, 8'h02, 8'h04, 8'h05, 8'h10, 8'h40, 8'h55, 8'h03, 8'h00, 8'hAA};

        AXI_RESET     = 1'b1;
        stat_reset    = 32'd0;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TDATA  = '0;
        S_AXIS_TSTRB  = '0;
        S_AXIS_TUSER  = '0;
        S_AXIS_TLAST  = 1'b0;
        M_AXIS_TREADY = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        AXI_RESET = 1'b0;
        chk("reset_tvalid", M_AXIS_TVALID, 1'b0);
        chk("reset_tdata", M_AXIS_TDATA, 256'd0);
        chk("reset_ttl_dec_count", ttl_dec_count, 32'd0);
        chk("reset_pass_count", pass_count, 32'd0);

        tab_dec = 0;
        for (int i = 0; i < 10; i++) begin
            b = mk(tab[i].et, tab[i].ver, tab[i].ttl, tab[i].pr, tab[i].cs, tab[i].dst, 1'b1);
            send(b);
            chk("vec_latency_tvalid", M_AXIS_TVALID, 1'b1);
            chk("vec_ttl", M_AXIS_TDATA[79:72], tab[i].ettl);
            chk("vec_csum", M_AXIS_TDATA[63:48], tab[i].ecs);
            if (!tab[i].mod) chk("vec_passthrough", M_AXIS_TDATA, b.d);
            if (tab[i].mod) tab_dec++;
        end
        drain();
        chk("vec_ttl_dec_count", ttl_dec_count, tab_dec);
        chk("vec_pass_count", pass_count, 10 - tab_dec);

        tready_mode = 1;
        n0 = n_out;
        for (int i = 0; i < 5; i++) send(mk(16'h0800, 4'd4, 8'h40, 8'h06, 16'hB1E6, 8'h01, i == 4));
        drain();
        chk("toggle_beat_count", n_out - n0, 5);
        chk_counters("toggle");

        tready_mode = 2;
        for (int p = 0; p < 60; p++) begin
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) begin
                et  = ($urandom_range(0, 7) == 0) ? 16'h0806 : 16'h0800;
                ver = ($urandom_range(0, 7) == 0) ? 4'd6 : 4'd4;
                b = mk(et, ver, 8'($urandom_range(0, 255)), 8'($urandom), 16'($urandom),
                       dsts[$urandom_range(0, 9)], k == len - 1);
                if ($urandom_range(0, 4) == 0) b.d[79:72] = 8'($urandom_range(0, 2));
                send(b);
            end
        end
        tready_mode = 0;
        drain();
        chk_counters("random");

        tready_mode = 3;
        repeat (2) @(posedge clk);
        #1;
        send(mk(16'h0800, 4'd4, 8'h40, 8'h06, 16'hB1E6, 8'h01, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        chk("held_beat_tvalid", M_AXIS_TVALID, 1'b1);
        AXI_RESET = 1'b1;
        @(posedge clk);
        #1;
        AXI_RESET = 1'b0;
        chk("midpkt_reset_tvalid", M_AXIS_TVALID, 1'b0);
        exp_q.delete();
        m_sop  = 1'b1;
        m_dec  = 0;
        m_pass = 0;
        m_port = '{0, 0, 0, 0};
        tready_mode = 0;
        send(mk(16'h0800, 4'd4, 8'h40, 8'h06, 16'hB1E6, 8'h01, 1'b1));
        chk("after_reset_sop_ttl", M_AXIS_TDATA[79:72], 8'h3F);
        drain();
        chk_counters("after_reset");

        stat_reset = 32'd1;
        send(mk(16'h0800, 4'd4, 8'h40, 8'h06, 16'hB1E6, 8'h05, 1'b1));
        stat_reset = 32'd0;
        m_dec  = 0;
        m_pass = 0;
        m_port = '{0, 0, 0, 0};
        chk_counters("stat_clear");
        send(mk(16'h0800, 4'd4, 8'h40, 8'h06, 16'hB1E6, 8'h05, 1'b1));
        drain();
        chk_counters("multicast");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
